// File: rtl/dbg_access_arb_pkg.sv
// ----------------------------------------------------------------------------
// dbg_access_arb_pkg
// Shared debug defines: FSM state encoding, target select codes, the default
// halt timeout and a helper that flags misaligned memory requests.
// Optional feature macro used by the arbiter: DBG_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package dbg_access_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HALT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    localparam int HALT_TIMEOUT_DEF = 255;

    // Memory accesses must be word aligned; register accesses ignore addr[1:0].
    function automatic logic misaligned(input logic sel, input logic [31:0] addr);
        return (sel == SEL_MEM) && (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dbg_access_arb_if.sv
// ----------------------------------------------------------------------------
// dbg_access_arb_if
// Bundles every non-clock/reset signal of the debug access arbiter:
//   requester side : req_i, we_i, sel_i, addr_i, wdata_i -> ack_o, err_o, rdata_o
//   core halt      : halt_req_o -> halt_ack_i
//   core ports     : op_req_o, reg_* (register file), mem_* (memory)
// slave  modport : seen by the arbiter
// master modport : seen by whoever drives requests and models the core
// ----------------------------------------------------------------------------
interface dbg_access_arb_if;

    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [1:0]  sel_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  ack_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;

    logic        halt_req_o;
    logic        halt_ack_i;
    logic        op_req_o;

    logic        reg_we_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [31:0] reg_rdata_i;

    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_i, we_i, sel_i, addr_i, wdata_i, halt_ack_i, reg_rdata_i, mem_rdata_i,
        output ack_o, err_o, rdata_o, halt_req_o, op_req_o,
               reg_we_o, reg_addr_o, reg_wdata_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, sel_i, addr_i, wdata_i, halt_ack_i, reg_rdata_i, mem_rdata_i,
        input  ack_o, err_o, rdata_o, halt_req_o, op_req_o,
               reg_we_o, reg_addr_o, reg_wdata_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dbg_rr_sel.sv
// ----------------------------------------------------------------------------
// dbg_rr_sel
// Two-way round-robin select. On a double request the requester that was
// served last loses; a single request always wins.
//   req   : request vector, bit0 = m0, bit1 = m1
//   last  : index of the requester served last
//   grant : index of the winning requester (don't care when req == 0)
// ----------------------------------------------------------------------------
module dbg_rr_sel (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        if (req == 2'b11) grant = ~last;
        else              grant = req[1];
    end

endmodule

// File: rtl/dbg_access_arb.sv
// ----------------------------------------------------------------------------
// dbg_access_arb
// Arbitrates two debug masters (m0 = JTAG DM, m1 = UART debugger) onto the
// core register-file and memory ports. A granted access halts the core,
// performs one single-cycle port access, then acknowledges the requester.
// Misaligned memory requests are rejected without halting the core.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dbg_access_arb_if.slave (requester, halt and core ports)
// Parameter HALT_TIMEOUT: halt wait limit, only used with DBG_TIMEOUT_EN.
// Macro DBG_TIMEOUT_EN: abort with err if the core does not halt in time.
// ----------------------------------------------------------------------------
module dbg_access_arb
    import dbg_access_arb_pkg::*;
#(
    parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    dbg_access_arb_if.slave bus
);

    // The halt counter is 8 bits wide, so the limit must fit in it.
    if (HALT_TIMEOUT < 1 || HALT_TIMEOUT > 255) begin : g_timeout_range
        $error("HALT_TIMEOUT must be in 1..255");
    end

    state_t      state, next_state;
    logic        grant;
    logic        last;      // requester served last (round-robin pointer)
    logic        cur;       // requester in service
    logic        we_q, sel_q, err_q, halt_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        halt_d;
    logic [31:0] req_addr, req_wdata;
    logic        req_bad, timeout_hit;

    dbg_rr_sel u_rr_sel (
        .req   (bus.req_i),
        .last  (last),
        .grant (grant)
    );

    assign req_addr  = grant ? bus.addr_i[63:32]  : bus.addr_i[31:0];
    assign req_wdata = grant ? bus.wdata_i[63:32] : bus.wdata_i[31:0];
    assign req_bad   = misaligned(bus.sel_i[grant], req_addr);

`ifdef DBG_TIMEOUT_EN
    logic [7:0] halt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                halt_cnt <= '0;
        else if (state == S_HALT)  halt_cnt <= halt_cnt + 8'd1;
        else                       halt_cnt <= '0;
    end

    assign timeout_hit = (halt_cnt == 8'(HALT_TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            S_IDLE:   if (|bus.req_i) next_state = req_bad ? S_RESP : S_HALT;
            S_HALT:   if (bus.halt_ack_i) next_state = S_ACCESS;
                      else if (timeout_hit) next_state = S_RESP;
            S_ACCESS: next_state = S_RESP;
            S_RESP:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Halt stays up through RESP only if the core was actually asked to halt;
    // a rejected misaligned request goes IDLE -> RESP with halt low.
    assign halt_d = (next_state == S_HALT) || (next_state == S_ACCESS) ||
                    ((next_state == S_RESP) && (state != S_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;   // m0 wins the first double request
            cur     <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= SEL_REG;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            halt_q <= halt_d;
            if (state == S_IDLE && |bus.req_i) begin
                cur     <= grant;
                last    <= grant;
                we_q    <= bus.we_i[grant];
                sel_q   <= bus.sel_i[grant];
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
                rdata_q <= '0;
            end
            if (state == S_ACCESS && !we_q) begin
                if (sel_q == SEL_MEM)          rdata_q <= bus.mem_rdata_i;
                else if (addr_q[4:0] == 5'd0)  rdata_q <= '0;   // x0 reads as zero
                else                           rdata_q <= bus.reg_rdata_i;
            end
            if (state == S_HALT && !bus.halt_ack_i && timeout_hit) err_q <= 1'b1;
        end
    end

    logic to_reg, to_mem;
    assign to_reg = (state == S_ACCESS) && (sel_q == SEL_REG);
    assign to_mem = (state == S_ACCESS) && (sel_q == SEL_MEM);

    assign bus.op_req_o    = (state == S_ACCESS);
    assign bus.reg_we_o    = to_reg && we_q && (addr_q[4:0] != 5'd0);
    assign bus.reg_addr_o  = to_reg ? addr_q[4:0] : 5'd0;
    assign bus.reg_wdata_o = to_reg ? wdata_q : 32'd0;
    assign bus.mem_we_o    = to_mem && we_q;
    assign bus.mem_addr_o  = to_mem ? addr_q : 32'd0;
    assign bus.mem_wdata_o = to_mem ? wdata_q : 32'd0;

    assign bus.ack_o      = (state == S_RESP) ? (cur ? 2'b10 : 2'b01) : 2'b00;
    assign bus.err_o      = (state == S_RESP && err_q) ? (cur ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rdata_o    = rdata_q;
    assign bus.halt_req_o = halt_q;

endmodule
